instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential fetch with a small in-order instruction queue.
//
// Issues one word-aligned read at a time to instruction memory, tags each returned
// word with the address it was fetched from, and buffers it in a FIFO toward decode.
// A redirect flushes the queue and restarts fetch at a new address. Any response
// that was already in flight when the redirect arrived is swallowed.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   mem_req/mem_addr  fetch request and word address, held until mem_gnt
//   mem_gnt           memory accepts the request this cycle
//   mem_rvalid/rdata  read response (one per granted request)
//   instr_valid/instr/instr_pc  queue head toward decode
//   instr_ready       decode consumes the head when instr_valid=1
//   redirect/redirect_pc  control-flow change; low two address bits are ignored
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(QDEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDrop = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     issue_pc_q, issue_pc_d;
  logic [31:0]     q_data [QDEPTH];
  logic [31:0]     q_pc   [QDEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop, room;

  // Low address bits of a redirect target are forced to zero.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // The queue is checked without crediting a same-cycle pop; with at most one
  // request outstanding this guarantees a slot for every response.
  assign room = (count_q < DepthCnt);
  assign pop  = instr_valid & instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    push       = 1'b0;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      case (state_q)
        // A granted request is in flight: wait out its response in StDrop.
        StReq:   state_d = mem_gnt ? StDrop : StIdle;
        StWait:  state_d = mem_rvalid ? StIdle : StDrop;
        // Response arriving together with a further redirect is discarded here,
        // nothing remains outstanding.
        StDrop:  state_d = mem_rvalid ? StIdle : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      case (state_q)
        StIdle: begin
          if (room) state_d = StReq;
        end
        StReq: begin
          if (mem_gnt) begin
            issue_pc_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;  // wraps silently at the top of memory
            state_d    = StWait;
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            push    = 1'b1;
            state_d = StIdle;
          end
        end
        StDrop: begin
          if (mem_rvalid) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CntW'(1);
          2'b01:   count_q <= count_q - CntW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr_q] <= mem_rdata;
      q_pc[wr_ptr_q]   <= issue_pc_q;
    end
  end

  assign mem_req     = (state_q == StReq);
  assign mem_addr    = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? q_data[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: bench-side memory model with configurable grant and
// response delays, and a scoreboard of expected fetch addresses. After every reset or
// redirect the expected instruction stream is simply target, target+4, ... with data
// given by a fixed function of the address.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int unsigned QD = 4;

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_gnt, mem_rvalid, instr_valid, instr_ready, redirect;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] salt;

  // Memory model state
  bit          pend;
  logic [31:0] pend_addr;
  int          rv_ctr, gnt_ctr, gnt_min, gnt_max, rv_min, rv_max;
  bit          spur_en;
  int          n_gnt;
  logic [31:0] gnt_log[$];

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  int          n_pop;

  // Directed-check flags
  bit          lat_chk, lat_pending, addr_chk;
  logic [31:0] addr_exp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cfg(input int gmin, input int gmax, input int rmin, input int rmax);
    gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
  endtask

  task automatic refill(input logic [31:0] base);
    exp_q.delete();
    next_pc = base;
  endtask

  // One clock: drive inputs at the falling edge, update the scoreboard after the
  // rising edge on which a reset or redirect takes effect.
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc,
                       input bit do_rst);
    @(negedge clk);
    if (lat_pending) begin
      chk("latency_valid", {31'b0, instr_valid}, 32'd1);
      lat_pending = 1'b0;
    end
    if (addr_chk && mem_req) begin
      chk("redirect_addr", mem_addr, addr_exp);
      addr_chk = 1'b0;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    mem_gnt    = 1'b0;
    if (pend) begin
      if (rv_ctr <= 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_addr);
        pend       = 1'b0;
        if (lat_chk) lat_pending = 1'b1;
      end else begin
        rv_ctr--;
      end
    end else if (spur_en && $urandom_range(0, 15) == 0) begin
      mem_rvalid = 1'b1;
    end
    if (!pend && mem_req === 1'b1) begin
      if (gnt_ctr <= 0) begin
        mem_gnt   = 1'b1;
        pend      = 1'b1;
        pend_addr = mem_addr;
        rv_ctr    = int'($urandom_range(rv_max, rv_min));
        gnt_ctr   = int'($urandom_range(gnt_max, gnt_min));
        n_gnt++;
        gnt_log.push_back(mem_addr);
      end else begin
        gnt_ctr--;
      end
    end
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    rst         = do_rst;
    @(posedge clk);
    #1;
    if (do_rst) refill(RST_PC);
    else if (redir) refill({rpc[31:2], 2'b00});
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc += 32'd4;
    end
  endtask

  // Monitor: checks every transfer toward decode against the scoreboard, plus the
  // hold rules for the queue head and an un-granted request.
  bit          prev_hold, prev_reqw;
  logic [31:0] prev_instr, prev_pc, prev_addr;
  initial begin
    prev_hold = 1'b0;
    prev_reqw = 1'b0;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (prev_hold) begin
      chk("head_valid_hold", {31'b0, instr_valid}, 32'd1);
      chk("head_instr_hold", instr, prev_instr);
      chk("head_pc_hold", instr_pc, prev_pc);
    end
    if (prev_reqw) begin
      chk("req_hold", {31'b0, mem_req}, 32'd1);
      chk("addr_hold", mem_addr, prev_addr);
    end
    if (mem_req === 1'b1) chk("addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
    if (rst === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", instr_pc, 32'hXXXX_XXXX);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e);
        chk("instr_data", instr, mem_word(e));
        n_pop++;
      end
    end
    prev_hold  = (instr_valid === 1'b1) && (instr_ready === 1'b0) &&
                 (redirect === 1'b0) && (rst === 1'b0);
    prev_reqw  = (mem_req === 1'b1) && (mem_gnt === 1'b0) &&
                 (redirect === 1'b0) && (rst === 1'b0);
    prev_instr = instr;
    prev_pc    = instr_pc;
    prev_addr  = mem_addr;
  end

  initial begin
    logic [31:0] wrap_exp [3];
    logic [31:0] rpc;
    int n0, r;
    bit ok;
    salt = $urandom;
    pend = 1'b0; pend_addr = '0; rv_ctr = 0; gnt_ctr = 0; spur_en = 1'b0; n_gnt = 0;
    n_pop = 0; next_pc = '0; lat_chk = 1'b0; lat_pending = 1'b0; addr_chk = 1'b0;
    addr_exp = '0;
    cfg(0, 0, 0, 0);
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    // First request in the second cycle after reset release; fetch wraps at the top
    gnt_log.delete();
    lat_chk = 1'b1;
    cycle(1, 0, 0, 0);
    chk("first_req", {31'b0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, RST_PC);
    repeat (14) cycle(1, 0, 0, 0);
    lat_chk = 1'b0;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++)
      chk($sformatf("wrap_addr%0d", i), (i < gnt_log.size()) ? gnt_log[i] : 32'hDEAD_BEEF,
          wrap_exp[i]);

    // Zero-wait memory from address 0
    cycle(1, 1, 32'h0, 0);
    n0 = n_pop;
    repeat (16) cycle(1, 0, 0, 0);
    chk("seq_progress", {31'b0, (n_pop - n0) >= 4}, 32'd1);

    // Decode stall: queue fills to exactly QD entries, then drains in order
    cycle(1, 1, 32'h200, 0);
    n0 = n_gnt;
    repeat (20) cycle(0, 0, 0, 0);
    chk("stall_grants", n_gnt - n0, QD);
    chk("stall_no_req", {31'b0, mem_req}, 32'd0);
    chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    n0 = n_pop;
    repeat (4) cycle(1, 0, 0, 0);
    chk("release_pops", n_pop - n0, 32'd4);

    // Redirect while a response is pending
    cfg(0, 0, 3, 3);
    for (int i = 0; i < 20 && !pend; i++) cycle(1, 0, 0, 0);
    chk("wait_reached", {31'b0, pend}, 32'd1);
    addr_chk = 1'b1;
    addr_exp = 32'h0000_1000;
    cycle(1, 1, 32'h0000_1003, 0);
    cfg(0, 0, 0, 0);
    n0 = n_pop;
    repeat (20) cycle(1, 0, 0, 0);
    chk("redirect_addr_seen", {31'b0, addr_chk}, 32'd0);
    chk("redirect_progress", {31'b0, (n_pop - n0) >= 3}, 32'd1);

    // Slow memory: grant after 3 cycles, response 5 cycles later
    cfg(3, 3, 5, 5);
    cycle(1, 1, 32'h4000, 0);
    n0 = n_pop;
    repeat (80) cycle(1, 0, 0, 0);
    chk("slow_progress", {31'b0, (n_pop - n0) >= 5}, 32'd1);

    // Reset with a response outstanding; stale data arrives two cycles later
    cfg(0, 0, 20, 20);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle(1, 0, 0, 0);
      ok = pend && (rv_ctr > 5);
    end
    chk("long_wait_reached", {31'b0, ok}, 32'd1);
    cycle(1, 0, 0, 1);
    rv_ctr = 1;
    cfg(0, 0, 0, 2);
    gnt_log.delete();
    n0 = n_pop;
    repeat (25) cycle(1, 0, 0, 0);
    chk("post_rst_addr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, RST_PC);
    chk("post_rst_progress", {31'b0, (n_pop - n0) >= 3}, 32'd1);

    // Randomised traffic
    cfg(0, 3, 0, 5);
    spur_en = 1'b1;
    n0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else rpc = $urandom;
      cycle($urandom_range(0, 9) < 7, r < 30, rpc, r >= 995);
    end
    spur_en = 1'b0;
    repeat (10) cycle(1, 0, 0, 0);
    chk("random_progress", {31'b0, (n_pop - n0) >= 300}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
